wb_hazard_pipe: RTL and testbench

- Producer side of the register-file write port. Tracks every in-flight register write through the E, M and W stages.
- Drives the register file's write-enable, address, data and PC8 signals from the W stage.
- Serves the decode-stage read side: resolves RAW hazards for the two read operands, producing forwarded data and a decode stall based on Tuse/Tnew.
- Sits between the decode stage and the register file in the 5-stage pipelined CPU.

---
 rtl/wb_hazard_pipe_pkg.sv | 40 ++++
 rtl/wb_fwd_sel.sv | 53 +++++
 rtl/wb_hazard_pipe.sv | 99 +++++++++
 tb/tb_wb_hazard_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_hazard_pipe_pkg.sv
// Shared types for the write-back hazard pipeline:
// in-flight write entries, result sources and Tnew.
package wb_hazard_pipe_pkg;

   localparam int WB_DW = 32;

   localparam logic [1:0] SRC_IMM = 2'd0;
   localparam logic [1:0] SRC_ALU = 2'd1;
   localparam logic [1:0] SRC_MEM = 2'd2;

   typedef enum logic [1:0] {
      STG_E,
      STG_M,
      STG_W
   } stage_t;

   typedef struct packed {
      logic             wen;
      logic [4:0]       a3;
      logic [1:0]       src;
      logic [WB_DW-1:0] wd;
      logic [WB_DW-1:0] pc8;
   } entry_t;

   // Cycles until the result of an entry in stage stg becomes forwardable.
   function automatic logic [1:0] tnew(
      input stage_t     stg,
      input logic [1:0] src
   );
      logic [1:0] t;
      t = 2'd0;
      unique case (stg)
         STG_E:   t = src;
         STG_M:   t = (src == SRC_MEM) ? 2'd1 : 2'd0;
         default: t = 2'd0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/wb_fwd_sel.sv
// Per-operand RAW resolver: picks the youngest matching in-flight write
// and derives forwarded data plus a stall request from Tnew vs Tuse.
module wb_fwd_sel
   import wb_hazard_pipe_pkg::*;
(
   input  entry_t           e_ent,
   input  entry_t           m_ent,
   input  entry_t           w_ent,
   input  logic [4:0]       addr,
   input  logic [1:0]       tuse,
   output logic             fwd_valid,
   output logic [WB_DW-1:0] fwd_data,
   output logic             stall_req
);

   logic             nz;
   logic             hit_e;
   logic             hit_m;
   logic             hit_w;
   logic             hit;
   logic [1:0]       t;
   logic [WB_DW-1:0] wd;

   assign nz    = (addr != 5'd0);
   assign hit_e = nz && e_ent.wen && (e_ent.a3 == addr);
   assign hit_m = nz && m_ent.wen && (m_ent.a3 == addr);
   assign hit_w = nz && w_ent.wen && (w_ent.a3 == addr);

   always_comb begin
      hit = 1'b0;
      t   = 2'd0;
      wd  = '0;
      if (hit_e) begin
         hit = 1'b1;
         t   = tnew(STG_E, e_ent.src);
         wd  = e_ent.wd;
      end else if (hit_m) begin
         hit = 1'b1;
         t   = tnew(STG_M, m_ent.src);
         wd  = m_ent.wd;
      end else if (hit_w) begin
         hit = 1'b1;
         t   = tnew(STG_W, w_ent.src);
         wd  = w_ent.wd;
      end
   end

   // A result is forwardable exactly when nothing is left to produce.
   assign fwd_valid = hit && (t == 2'd0);
   assign fwd_data  = fwd_valid ? wd : '0;
   assign stall_req = hit && (t > tuse);

endmodule

// File: rtl/wb_hazard_pipe.sv
// Tracks in-flight GPR writes through E/M/W, drives the register-file
// write port from W and resolves decode-stage RAW hazards.
module wb_hazard_pipe
   import wb_hazard_pipe_pkg::*;
#(
   parameter int DW = WB_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic          issue_wen,
   input  logic [4:0]    issue_a3,
   input  logic [1:0]    issue_src,
   input  logic [DW-1:0] issue_wd,
   input  logic [DW-1:0] issue_pc8,
   input  logic [DW-1:0] e_wd,
   input  logic [DW-1:0] m_wd,
   input  logic [4:0]    rs_addr,
   input  logic [4:0]    rt_addr,
   input  logic [1:0]    rs_tuse,
   input  logic [1:0]    rt_tuse,
   output logic          stall,
   output logic          fwd_rs_valid,
   output logic          fwd_rt_valid,
   output logic [DW-1:0] fwd_rs_data,
   output logic [DW-1:0] fwd_rt_data,
   output logic          grf_we,
   output logic [4:0]    grf_a3,
   output logic [DW-1:0] grf_wd,
   output logic [DW-1:0] grf_pc8
);

   entry_t     e_q;
   entry_t     m_q;
   entry_t     w_q;
   entry_t     e_d;
   logic [1:0] src_n;
   logic       rs_stall;
   logic       rt_stall;

   // Illegal source 3 behaves like a load.
   assign src_n = (issue_src == 2'd3) ? SRC_MEM : issue_src;

   always_comb begin
      e_d = '0;
      if (issue_valid && !stall) begin
         e_d.wen = issue_wen && (issue_a3 != 5'd0);
         e_d.a3  = issue_a3;
         e_d.src = src_n;
         e_d.wd  = (src_n == SRC_IMM) ? issue_wd : '0;
         e_d.pc8 = issue_pc8;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= e_q;
         if (e_q.src == SRC_ALU)
            m_q.wd <= e_wd;
         w_q <= m_q;
         if (m_q.src == SRC_MEM)
            w_q.wd <= m_wd;
      end
   end

   wb_fwd_sel u_rs (
      .e_ent     (e_q),
      .m_ent     (m_q),
      .w_ent     (w_q),
      .addr      (rs_addr),
      .tuse      (rs_tuse),
      .fwd_valid (fwd_rs_valid),
      .fwd_data  (fwd_rs_data),
      .stall_req (rs_stall)
   );

   wb_fwd_sel u_rt (
      .e_ent     (e_q),
      .m_ent     (m_q),
      .w_ent     (w_q),
      .addr      (rt_addr),
      .tuse      (rt_tuse),
      .fwd_valid (fwd_rt_valid),
      .fwd_data  (fwd_rt_data),
      .stall_req (rt_stall)
   );

   assign stall   = rs_stall || rt_stall;
   assign grf_we  = w_q.wen;
   assign grf_a3  = w_q.a3;
   assign grf_wd  = w_q.wd;
   assign grf_pc8 = w_q.pc8;

endmodule

// File: tb/tb_wb_hazard_pipe.sv
// Directed bench for wb_hazard_pipe: register-file writes are checked
// against a scoreboard of expected writes, hazard outputs inline.
module tb_wb_hazard_pipe;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid;
   logic          issue_wen;
   logic [4:0]    issue_a3;
   logic [1:0]    issue_src;
   logic [DW-1:0] issue_wd;
   logic [DW-1:0] issue_pc8;
   logic [DW-1:0] e_wd;
   logic [DW-1:0] m_wd;
   logic [4:0]    rs_addr;
   logic [4:0]    rt_addr;
   logic [1:0]    rs_tuse;
   logic [1:0]    rt_tuse;
   logic          stall;
   logic          fwd_rs_valid;
   logic          fwd_rt_valid;
   logic [DW-1:0] fwd_rs_data;
   logic [DW-1:0] fwd_rt_data;
   logic          grf_we;
   logic [4:0]    grf_a3;
   logic [DW-1:0] grf_wd;
   logic [DW-1:0] grf_pc8;

   typedef struct {
      int unsigned   at;
      logic [4:0]    a3;
      logic [DW-1:0] wd;
      logic [DW-1:0] pc8;
   } wr_t;

   wr_t         sb[$];
   int unsigned edges = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   wb_hazard_pipe #(.DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_wen    (issue_wen),
      .issue_a3     (issue_a3),
      .issue_src    (issue_src),
      .issue_wd     (issue_wd),
      .issue_pc8    (issue_pc8),
      .e_wd         (e_wd),
      .m_wd         (m_wd),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_tuse      (rs_tuse),
      .rt_tuse      (rt_tuse),
      .stall        (stall),
      .fwd_rs_valid (fwd_rs_valid),
      .fwd_rt_valid (fwd_rt_valid),
      .fwd_rs_data  (fwd_rs_data),
      .fwd_rt_data  (fwd_rt_data),
      .grf_we       (grf_we),
      .grf_a3       (grf_a3),
      .grf_wd       (grf_wd),
      .grf_pc8      (grf_pc8)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic wen, input logic [4:0] a3,
                        input logic [1:0] src, input logic [DW-1:0] wd,
                        input logic [DW-1:0] pc8);
      issue_valid = 1'b1;
      issue_wen   = wen;
      issue_a3    = a3;
      issue_src   = src;
      issue_wd    = wd;
      issue_pc8   = pc8;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_wen   = 1'b0;
      issue_a3    = 5'd0;
      issue_src   = 2'd0;
      issue_wd    = '0;
      issue_pc8   = '0;
   endtask

   // Expect a write issued on the coming edge two edges after it.
   task automatic push(input logic [4:0] a3, input logic [DW-1:0] wd,
                       input logic [DW-1:0] pc8);
      wr_t w;
      w.at  = edges + 3;
      w.a3  = a3;
      w.wd  = wd;
      w.pc8 = pc8;
      sb.push_back(w);
   endtask

   task automatic step();
      if (rst)
         sb.delete();
      @(posedge clk);
      edges++;
      #1;
      if (sb.size() > 0 && sb[0].at == edges) begin
         chk("grf_we", grf_we, 1);
         chk("grf_a3", grf_a3, sb[0].a3);
         chk("grf_wd", grf_wd, sb[0].wd);
         chk("grf_pc8", grf_pc8, sb[0].pc8);
         void'(sb.pop_front());
      end else begin
         chk("grf_we_idle", grf_we, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      e_wd    = '0;
      m_wd    = '0;
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      rs_tuse = 2'd0;
      rt_tuse = 2'd0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_a3", grf_a3, 0);
      chk("rst_wd", grf_wd, 0);
      chk("rst_pc8", grf_pc8, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rs_valid", fwd_rs_valid, 0);
      chk("rst_rt_valid", fwd_rt_valid, 0);

      // ALU chain
      drive(1'b1, 5'd3, 2'd1, '0, 32'h1000);
      push(5'd3, 32'h1234, 32'h1000);
      step();
      idle();
      e_wd    = 32'h1234;
      rs_addr = 5'd3;
      rs_tuse = 2'd1;
      #1;
      chk("alu_e_stall", stall, 0);
      chk("alu_e_valid", fwd_rs_valid, 0);
      step();
      e_wd = 32'h0;
      #1;
      chk("alu_m_valid", fwd_rs_valid, 1);
      chk("alu_m_data", fwd_rs_data, 32'h1234);
      chk("alu_m_stall", stall, 0);
      step();
      rs_addr = 5'd0;
      step();

      // Load-use, with a dropped issue during the stall
      drive(1'b1, 5'd5, 2'd2, '0, 32'h2000);
      push(5'd5, 32'hBEEF, 32'h2000);
      step();
      drive(1'b1, 5'd9, 2'd0, 32'h99, 32'h2004);
      rs_addr = 5'd5;
      rs_tuse = 2'd0;
      #1;
      chk("lw_stall1", stall, 1);
      chk("lw_valid1", fwd_rs_valid, 0);
      step();
      idle();
      m_wd = 32'hBEEF;
      #1;
      chk("lw_stall2", stall, 1);
      step();
      m_wd = 32'h0;
      #1;
      chk("lw_stall3", stall, 0);
      chk("lw_valid3", fwd_rs_valid, 1);
      chk("lw_data3", fwd_rs_data, 32'hBEEF);
      rs_addr = 5'd0;
      step();
      step();

      // $0 destination
      drive(1'b1, 5'd0, 2'd1, '0, 32'h2100);
      step();
      idle();
      e_wd    = 32'h5555;
      rs_addr = 5'd0;
      rs_tuse = 2'd0;
      #1;
      chk("z_stall", stall, 0);
      chk("z_valid", fwd_rs_valid, 0);
      step();
      step();
      step();

      // Priority E over M, then M over W
      drive(1'b1, 5'd7, 2'd0, 32'h11, 32'h3000);
      push(5'd7, 32'h11, 32'h3000);
      step();
      drive(1'b1, 5'd7, 2'd0, 32'h22, 32'h3004);
      push(5'd7, 32'h22, 32'h3004);
      step();
      idle();
      rt_addr = 5'd7;
      rt_tuse = 2'd0;
      #1;
      chk("pri_em_valid", fwd_rt_valid, 1);
      chk("pri_em_data", fwd_rt_data, 32'h22);
      step();
      chk("pri_mw_data", fwd_rt_data, 32'h22);
      step();
      rt_addr = 5'd0;
      step();

      // Source 3 behaves like a load
      drive(1'b1, 5'd10, 2'd3, '0, 32'h4000);
      push(5'd10, 32'hCAFE, 32'h4000);
      step();
      idle();
      rt_addr = 5'd10;
      rt_tuse = 2'd1;
      #1;
      chk("s3_stall_e", stall, 1);
      step();
      m_wd = 32'hCAFE;
      #1;
      chk("s3_stall_m", stall, 0);
      chk("s3_valid_m", fwd_rt_valid, 0);
      step();
      m_wd = 32'h0;
      #1;
      chk("s3_valid_w", fwd_rt_valid, 1);
      chk("s3_data_w", fwd_rt_data, 32'hCAFE);
      rt_addr = 5'd0;
      step();

      // Reset with three writes in flight
      drive(1'b1, 5'd12, 2'd0, 32'h12, 32'h5000);
      push(5'd12, 32'h12, 32'h5000);
      step();
      drive(1'b1, 5'd13, 2'd1, '0, 32'h5004);
      e_wd = 32'hE13;
      push(5'd13, 32'hE13, 32'h5004);
      step();
      drive(1'b1, 5'd14, 2'd2, '0, 32'h5008);
      m_wd = 32'hAAAA;
      push(5'd14, 32'hAAAA, 32'h5008);
      step();
      drive(1'b1, 5'd15, 2'd0, 32'h15, 32'h500C);
      rst     = 1'b1;
      rs_addr = 5'd13;
      rt_addr = 5'd14;
      rs_tuse = 2'd0;
      rt_tuse = 2'd0;
      step();
      rst = 1'b0;
      idle();
      #1;
      chk("rmf_a3", grf_a3, 0);
      chk("rmf_wd", grf_wd, 0);
      chk("rmf_pc8", grf_pc8, 0);
      chk("rmf_rs_valid", fwd_rs_valid, 0);
      chk("rmf_rt_valid", fwd_rt_valid, 0);
      chk("rmf_stall", stall, 0);
      step();
      step();
      step();
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      e_wd    = 32'h0;
      m_wd    = 32'h0;

      // Link forward
      drive(1'b1, 5'd31, 2'd0, 32'h3008, 32'h3008);
      push(5'd31, 32'h3008, 32'h3008);
      step();
      idle();
      rs_addr = 5'd31;
      rs_tuse = 2'd0;
      #1;
      chk("lnk_valid", fwd_rs_valid, 1);
      chk("lnk_data", fwd_rs_data, 32'h3008);
      chk("lnk_stall", stall, 0);
      step();
      step();
      step();
      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
